// File: rtl/typer_pkg.sv
// Shared decode constants, ALU operation encoding and the R-type decoder.
package typer_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
    } dec_t;

    // ADD/SUB share the wrapping datapath of ADDU/SUBU: no overflow trap exists.
    function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        dec_t d;
        d.legal = 1'b0;
        d.op    = OP_ADD;
        if (opcode == OPC_RTYPE) begin
            d.legal = 1'b1;
            case (funct)
                FN_ADD, FN_ADDU: d.op = OP_ADD;
                FN_SUB, FN_SUBU: d.op = OP_SUB;
                FN_AND:          d.op = OP_AND;
                FN_OR:           d.op = OP_OR;
                FN_XOR:          d.op = OP_XOR;
                FN_NOR:          d.op = OP_NOR;
                FN_SLT:          d.op = OP_SLT;
                FN_SLTU:         d.op = OP_SLTU;
                FN_SLL:          d.op = OP_SLL;
                FN_SRL:          d.op = OP_SRL;
                FN_SRA:          d.op = OP_SRA;
                default:         d.legal = 1'b0;
            endcase
        end else begin
            d.legal = 1'b0;
        end
        return d;
    endfunction

endpackage

// File: rtl/typer_alu.sv
// Combinational R-type ALU: wrapping arithmetic, logic ops, compares and shifts.
module typer_alu
    import typer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    output logic [DATA_W-1:0] y
);

    // Result select; shifts use rt (b) as the source operand.
    always_comb begin
        y = {DATA_W{1'b0}};
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_SLT:  y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: y = {{(DATA_W-1){1'b0}}, (a < b)};
            OP_SLL:  y = b << shamt;
            OP_SRL:  y = b >> shamt;
            OP_SRA:  y = $signed(b) >>> shamt;
            default: y = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/typer_pipe.sv
// Three-stage (ID -> EX -> WB) R-type core with inline regfile and full bypassing.
// A result is visible to a consumer from three places while in flight: the
// EX/WB register, the WB output register, and finally the regfile.
module typer_pipe
    import typer_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREG      = 32,
    parameter int CNT_W     = 16,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              wb_valid,
    output logic [4:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired,
    input  logic [4:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    // 5-bit register fields wrap modulo NREG.
    function automatic logic [IW-1:0] to_idx(input logic [4:0] a);
        return IW'({27'd0, a} % NREG);
    endfunction

    logic [DATA_W-1:0] rf_q [NREG];

    logic              idex_valid_q;
    alu_op_e           idex_op_q;
    logic [IW-1:0]     idex_rs_q, idex_rt_q;
    logic [4:0]        idex_rd_q, idex_shamt_q;
    logic [DATA_W-1:0] idex_a_q, idex_b_q;

    logic              exwb_valid_q;
    logic [4:0]        exwb_rd_q;
    logic [DATA_W-1:0] exwb_data_q;

    logic              wb_valid_q;
    logic [4:0]        wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              illegal_q;
    logic [CNT_W-1:0]  retired_q;

    logic              accept_s;
    dec_t              dec_s;
    logic [IW-1:0]     rs_idx_s, rt_idx_s, exwb_idx_s, wb_idx_s, dbg_idx_s;
    logic              exwb_fwd_s, wb_fwd_s;
    logic [DATA_W-1:0] id_a_s, id_b_s, ex_a_s, ex_b_s, alu_y_s;

    assign instr_ready = reset & ~freeze;
    assign accept_s    = instr_valid & instr_ready;
    assign dec_s       = decode(instr[31:26], instr[5:0]);
    assign rs_idx_s    = to_idx(instr[25:21]);
    assign rt_idx_s    = to_idx(instr[20:16]);
    assign exwb_idx_s  = to_idx(exwb_rd_q);
    assign wb_idx_s    = to_idx(wb_addr_q);
    assign dbg_idx_s   = to_idx(dbg_addr);
    // Writes to register 0 never feed a consumer.
    assign exwb_fwd_s  = exwb_valid_q & (exwb_idx_s != '0);
    assign wb_fwd_s    = wb_valid_q & (wb_idx_s != '0);

    // ID operand read: the youngest in-flight producer wins over the regfile.
    always_comb begin
        id_a_s = {DATA_W{1'b0}};
        id_b_s = {DATA_W{1'b0}};
        if (rs_idx_s == '0)                            id_a_s = {DATA_W{1'b0}};
        else if (exwb_fwd_s && exwb_idx_s == rs_idx_s) id_a_s = exwb_data_q;
        else if (wb_fwd_s && wb_idx_s == rs_idx_s)     id_a_s = wb_data_q;
        else                                           id_a_s = rf_q[rs_idx_s];
        if (rt_idx_s == '0)                            id_b_s = {DATA_W{1'b0}};
        else if (exwb_fwd_s && exwb_idx_s == rt_idx_s) id_b_s = exwb_data_q;
        else if (wb_fwd_s && wb_idx_s == rt_idx_s)     id_b_s = wb_data_q;
        else                                           id_b_s = rf_q[rt_idx_s];
    end

    // EX forwarding: the immediately preceding result overrides the latched read.
    always_comb begin
        ex_a_s = idex_a_q;
        ex_b_s = idex_b_q;
        if (exwb_fwd_s && exwb_idx_s == idex_rs_q) ex_a_s = exwb_data_q;
        else                                       ex_a_s = idex_a_q;
        if (exwb_fwd_s && exwb_idx_s == idex_rt_q) ex_b_s = exwb_data_q;
        else                                       ex_b_s = idex_b_q;
    end

    typer_alu #(.DATA_W(DATA_W)) u_alu (
        .op    (idex_op_q),
        .a     (ex_a_s),
        .b     (ex_b_s),
        .shamt (idex_shamt_q),
        .y     (alu_y_s)
    );

    // Pipeline advance: every stage register and the retire count hold under freeze.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idex_valid_q <= 1'b0;
            idex_op_q    <= OP_ADD;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_rd_q    <= 5'd0;
            idex_shamt_q <= 5'd0;
            idex_a_q     <= {DATA_W{1'b0}};
            idex_b_q     <= {DATA_W{1'b0}};
            exwb_valid_q <= 1'b0;
            exwb_rd_q    <= 5'd0;
            exwb_data_q  <= {DATA_W{1'b0}};
            wb_valid_q   <= 1'b0;
            wb_addr_q    <= 5'd0;
            wb_data_q    <= {DATA_W{1'b0}};
            retired_q    <= {CNT_W{1'b0}};
        end else if (!freeze) begin
            idex_valid_q <= accept_s & dec_s.legal;
            if (accept_s) begin
                idex_op_q    <= dec_s.op;
                idex_rs_q    <= rs_idx_s;
                idex_rt_q    <= rt_idx_s;
                idex_rd_q    <= instr[15:11];
                idex_shamt_q <= instr[10:6];
                idex_a_q     <= id_a_s;
                idex_b_q     <= id_b_s;
            end
            exwb_valid_q <= idex_valid_q;
            if (idex_valid_q) begin
                exwb_rd_q   <= idex_rd_q;
                exwb_data_q <= alu_y_s;
            end
            wb_valid_q <= exwb_valid_q;
            if (exwb_valid_q) begin
                wb_addr_q <= exwb_rd_q;
                wb_data_q <= exwb_data_q;
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Illegal pulse: one cycle per rejected accept, never stretched by freeze.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) illegal_q <= 1'b0;
        else        illegal_q <= accept_s & ~dec_s.legal;
    end

    // Regfile commit at the edge that closes the wb_valid cycle; register 0 stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREG; k++)
                rf_q[k] <= (INIT_MODE == 1) ? DATA_W'(k) : {DATA_W{1'b0}};
        end else if (!freeze && wb_fwd_s) begin
            rf_q[wb_idx_s] <= wb_data_q;
        end
    end

    // Debug read sees the value being written this cycle.
    always_comb begin
        dbg_data = {DATA_W{1'b0}};
        if (dbg_idx_s == '0)                         dbg_data = {DATA_W{1'b0}};
        else if (wb_fwd_s && wb_idx_s == dbg_idx_s)  dbg_data = wb_data_q;
        else                                         dbg_data = rf_q[dbg_idx_s];
    end

    assign wb_valid = wb_valid_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign illegal  = illegal_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_typer_pipe.sv
// Bench for typer_pipe: directed plan steps followed by random traffic,
// checked against an architectural (program-order) reference model.
module tb_typer_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        illegal;
    logic [15:0] retired;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] dbg_data;

    typer_pipe #(.DATA_W(32), .NREG(32), .CNT_W(16), .INIT_MODE(1)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .retired(retired),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  addr;
        logic [31:0] data;
    } pend_t;

    int          n_checks = 0;
    int          n_err = 0;
    int          tick = 0;
    pend_t       pend[$];
    logic [31:0] mrf [32];
    logic        e_wbv = 1'b0;
    logic [4:0]  e_addr = 5'd0;
    logic [31:0] e_data = 32'd0;
    logic        e_ill = 1'b0;
    logic [15:0] e_ret = 16'd0;
    logic [5:0]  fn_tab [13];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd,
                                          input int sh, input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    task automatic model_init();
        for (int k = 0; k < 32; k++) mrf[k] = 32'(k);
    endtask

    // Architectural meaning of one instruction, applied in program order.
    task automatic model_exec(input logic [31:0] ins, output bit leg, output logic [31:0] res);
        logic [31:0] a, b;
        int sh;
        a   = mrf[ins[25:21]];
        b   = mrf[ins[20:16]];
        sh  = int'(ins[10:6]);
        leg = (ins[31:26] == 6'd0);
        res = 32'd0;
        case (ins[5:0])
            6'h20, 6'h21: res = a + b;
            6'h22, 6'h23: res = a - b;
            6'h24: res = a & b;
            6'h25: res = a | b;
            6'h26: res = a ^ b;
            6'h27: res = ~(a | b);
            6'h2a: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2b: res = (a < b) ? 32'd1 : 32'd0;
            6'h00: res = b << sh;
            6'h02: res = b >> sh;
            6'h03: res = 32'($signed(b) >>> sh);
            default: leg = 1'b0;
        endcase
        if (leg && ins[15:11] != 5'd0) mrf[ins[15:11]] = res;
    endtask

    // One clock: drive at the falling edge, check after the next falling edge.
    task automatic step(input bit v, input logic [31:0] ins, input bit frz);
        bit acc, leg;
        logic [31:0] res;
        pend_t p;
        instr_valid = v; instr = ins; freeze = frz;
        #1;
        chk("instr_ready", instr_ready, !frz);
        acc = v && !frz;
        leg = 1'b0;
        if (acc) begin
            model_exec(ins, leg, res);
            if (leg) pend.push_back('{tick + 3, ins[15:11], res});
        end
        @(posedge clk);
        @(negedge clk);
        if (!frz) begin
            tick++;
            e_wbv = 1'b0;
            if (pend.size() > 0 && pend[0].due == tick) begin
                p = pend.pop_front();
                e_wbv = 1'b1; e_addr = p.addr; e_data = p.data; e_ret = e_ret + 16'd1;
            end
        end
        e_ill = acc && !leg;
        chk("wb_valid", wb_valid, e_wbv);
        chk("illegal", illegal, e_ill);
        chk("retired", retired, e_ret);
        if (e_wbv) begin
            chk("wb_addr", wb_addr, e_addr);
            chk("wb_data", wb_data, e_data);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0);
    endtask

    task automatic do_reset();
        instr_valid = 1'b0; freeze = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_wb_addr", wb_addr, 5'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_retired", retired, 16'd0);
        chk("rst_instr_ready", instr_ready, 1'b0);
        model_init();
        pend.delete();
        e_wbv = 1'b0; e_ill = 1'b0; e_ret = 16'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic dbg_expect(input int a, input logic [31:0] v);
        dbg_addr = 5'(a);
        #1;
        chk($sformatf("dbg_r%0d", a), dbg_data, v);
    endtask

    task automatic dbg_all();
        for (int k = 0; k < 32; k++) dbg_expect(k, mrf[k]);
    endtask

    initial begin
        logic [31:0] ins;
        bit v, frz;
        fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                   6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03};
        #1;
        do_reset();
        dbg_expect(5, 32'd5);

        // Single op
        step(1'b1, 32'h00221820, 1'b0);
        idle(4);
        dbg_expect(3, 32'd3);

        // Forwarding chain
        step(1'b1, rtype(2, 1, 4, 0, 6'h22), 1'b0);
        step(1'b1, rtype(4, 4, 5, 0, 6'h20), 1'b0);
        step(1'b1, rtype(0, 5, 6, 4, 6'h00), 1'b0);
        idle(4);
        dbg_expect(4, 32'd1);
        dbg_expect(5, 32'd2);
        dbg_expect(6, 32'd32);

        // Signedness
        step(1'b1, rtype(0, 1, 7, 0, 6'h22), 1'b0);
        step(1'b1, rtype(7, 1, 8, 0, 6'h2a), 1'b0);
        step(1'b1, rtype(7, 1, 9, 0, 6'h2b), 1'b0);
        step(1'b1, rtype(0, 7, 10, 3, 6'h03), 1'b0);
        step(1'b1, rtype(0, 7, 11, 28, 6'h02), 1'b0);
        idle(4);
        dbg_expect(7, 32'hFFFFFFFF);
        dbg_expect(8, 32'd1);
        dbg_expect(9, 32'd0);
        dbg_expect(10, 32'hFFFFFFFF);
        dbg_expect(11, 32'h0000000F);

        // Illegal and register-zero writes
        step(1'b1, rtype(1, 2, 12, 0, 6'h08), 1'b0);
        step(1'b1, {6'h08, 26'h0221820}, 1'b0);
        idle(3);
        step(1'b1, 32'h00220020, 1'b0);
        idle(4);
        dbg_expect(0, 32'd0);

        // Freeze with two instructions in flight
        step(1'b1, rtype(1, 2, 12, 0, 6'h20), 1'b0);
        step(1'b1, rtype(12, 1, 13, 0, 6'h22), 1'b0);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 1'b1);
        idle(4);
        dbg_expect(12, 32'd3);
        dbg_expect(13, 32'd2);

        // Reset with two instructions in flight
        step(1'b1, rtype(3, 3, 3, 0, 6'h20), 1'b0);
        step(1'b1, rtype(3, 3, 3, 0, 6'h20), 1'b0);
        do_reset();
        idle(4);
        dbg_expect(3, 32'd3);
        dbg_all();

        // Random traffic on a small register window to force dependencies
        for (int it = 0; it < 1500; it++) begin
            v   = ($urandom_range(0, 3) != 0);
            frz = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 11) == 0) begin
                if ($urandom_range(0, 1) == 0) ins = {6'($urandom_range(1, 63)), 26'($urandom)};
                else ins = rtype($urandom_range(0, 7), $urandom_range(0, 7),
                                 $urandom_range(0, 7), 0, 6'h08);
            end else begin
                ins = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 31), fn_tab[$urandom_range(0, 12)]);
            end
            step(v, ins, frz);
            if (it % 250 == 249) begin
                idle(4);
                dbg_all();
            end
            if (it == 700) do_reset();
        end
        idle(4);
        dbg_all();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
